// File: rtl/prog_mem_loader.sv
// prog_mem_loader: parametrised program/data memory with a front-panel loader
// for the 8-bit SAP-style core.
//
// Optional feature macro: PROG_PROTECT_EN
//   defined   - RUN-mode core writes to addresses 0..PROT_TOP are dropped and
//               set the sticky prot_err flag; loader writes are never blocked.
//   undefined - every core write is accepted, prot_err is tied 0.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   start        1 requests RUN mode, 0 requests LOAD mode
//   addr_mode    0 = load address from sw_addr, 1 = auto-increment pointer
//   sw_addr      switch address
//   sw_data      switch data
//   load_btn     raw (bouncy, asynchronous) load button
//   cpu_addr     core address
//   cpu_wr_en    core write strobe (honoured only in RUN)
//   cpu_wr_data  core write data
//   cpu_rd_data  combinational read data (core address in RUN, load address otherwise)
//   run          1 while in RUN
//   load_addr    address the next loader write will target
//   load_ack     one-cycle pulse on each loader write
//   wr_count     saturating count of loader writes since reset
//   prot_err     sticky protection violation flag
module prog_mem_loader #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int DEB_CYCLES = 4,
    parameter int PROT_TOP   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              addr_mode,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              load_btn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wr_en,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              run,
    output logic [ADDR_W-1:0] load_addr,
    output logic              load_ack,
    output logic [ADDR_W:0]   wr_count,
    output logic              prot_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int          CNT_W = $clog2(DEB_CYCLES + 1);

    if (DEB_CYCLES < 1 || PROT_TOP < 0 || PROT_TOP >= 2 ** ADDR_W) begin : g_param_check
        $error("prog_mem_loader: DEB_CYCLES must be >= 1 and PROT_TOP within the address range");
    end

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_WRITE,
        ST_RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              btn_meta;
    logic              btn_sync;
    logic              btn_deb;
    logic [CNT_W-1:0]  deb_cnt;
    logic              press_evt;
    logic [ADDR_W-1:0] ptr;
    logic              cpu_we_ok;

    // ---------------- button conditioning ----------------
    // press_evt is registered together with the 0->1 flip of btn_deb, so it
    // is high in the first cycle the debounced level reads 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            btn_deb   <= 1'b0;
            deb_cnt   <= '0;
            press_evt <= 1'b0;
        end else begin
            btn_meta  <= load_btn;
            btn_sync  <= btn_meta;
            press_evt <= 1'b0;
            if (btn_sync == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                btn_deb   <= btn_sync;
                deb_cnt   <= '0;
                press_evt <= btn_sync;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // ---------------- mode FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= ST_LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_LOAD: begin
                if (press_evt)  state_nxt = ST_WRITE;
                else if (start) state_nxt = ST_RUN;
            end
            ST_WRITE: state_nxt = start ? ST_RUN : ST_LOAD;
            ST_RUN:   if (!start) state_nxt = ST_LOAD;
            default:  state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        run      = (state == ST_RUN);
        load_ack = (state == ST_WRITE);
    end

    // ---------------- protection ----------------
`ifdef PROG_PROTECT_EN
    logic prot_hit;
    assign prot_hit  = (cpu_addr <= ADDR_W'(PROT_TOP));
    assign cpu_we_ok = cpu_wr_en && !prot_hit;

    always_ff @(posedge clk) begin
        if (reset)                                      prot_err <= 1'b0;
        else if (state == ST_RUN && cpu_wr_en && prot_hit) prot_err <= 1'b1;
    end
`else
    assign cpu_we_ok = cpu_wr_en;
    assign prot_err  = 1'b0;
`endif

    // ---------------- loader bookkeeping ----------------
    assign load_addr = addr_mode ? ptr : sw_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            wr_count <= '0;
        end else if (state == ST_WRITE) begin
            if (addr_mode)       ptr      <= ptr + 1'b1;
            if (wr_count != '1)  wr_count <= wr_count + 1'b1;
        end
    end

    // ---------------- memory ----------------
    // Reset has priority, so a reset landing on the WRITE cycle drops the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == ST_WRITE) begin
            mem[load_addr] <= sw_data;
        end else if (state == ST_RUN && cpu_we_ok) begin
            mem[cpu_addr] <= cpu_wr_data;
        end
    end

    assign cpu_rd_data = (state == ST_RUN) ? mem[cpu_addr] : mem[load_addr];

endmodule

// File: tb/tb_prog_mem_loader.sv
module tb_prog_mem_loader;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 4;
    localparam int DEB      = 4;
    localparam int PROT_TOP = 7;
    localparam int DEPTH    = 16;
    localparam int WIN      = 13 + DEB + 6;
`ifdef PROG_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              addr_mode = 1'b0;
    logic [ADDR_W-1:0] sw_addr = '0;
    logic [DATA_W-1:0] sw_data = '0;
    logic              load_btn = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic              cpu_wr_en = 1'b0;
    logic [DATA_W-1:0] cpu_wr_data = '0;
    logic [DATA_W-1:0] cpu_rd_data;
    logic              run;
    logic [ADDR_W-1:0] load_addr;
    logic              load_ack;
    logic [ADDR_W:0]   wr_count;
    logic              prot_err;

    prog_mem_loader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEB_CYCLES(DEB),
        .PROT_TOP(PROT_TOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .addr_mode(addr_mode),
        .sw_addr(sw_addr),
        .sw_data(sw_data),
        .load_btn(load_btn),
        .cpu_addr(cpu_addr),
        .cpu_wr_en(cpu_wr_en),
        .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data),
        .run(run),
        .load_addr(load_addr),
        .load_ack(load_ack),
        .wr_count(wr_count),
        .prot_err(prot_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_cnt;
    int                m_ptr;
    bit                m_prot;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_cnt  = 0;
        m_ptr  = 0;
        m_prot = 1'b0;
    endtask

    task automatic model_load();
        int a;
        a = addr_mode ? m_ptr : int'(sw_addr);
        m_mem[a] = sw_data;
        if (m_cnt < 31) m_cnt++;
        if (addr_mode) m_ptr = (m_ptr + 1) % DEPTH;
    endtask

    task automatic model_cpu_write(input int a, input logic [DATA_W-1:0] d);
        if (PROT && a <= PROT_TOP) m_prot = 1'b1;
        else                       m_mem[a] = d;
    endtask

    task automatic apply_reset();
        reset = 1'b1; load_btn = 1'b0; start = 1'b0; cpu_wr_en = 1'b0;
        tick(); tick();
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one press (clean: 10 high cycles; bouncy: 1,0,1 then 10 high),
    // counts load_ack pulses, and records the cycle of the first one.
    task automatic press(input bit bouncy, input bit expect_write, output int acks, output int first);
        acks  = 0;
        first = -1;
        for (int i = 0; i < WIN; i++) begin
            if (bouncy) load_btn = (i == 1) ? 1'b0 : (i < 13);
            else        load_btn = (i < 10);
            tick();
            if (load_ack === 1'b1) begin
                acks++;
                if (first < 0) first = i + 1;
            end
        end
        load_btn = 1'b0;
        if (expect_write) model_load();
    endtask

    task automatic readback_all(input string tag);
        addr_mode = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            sw_addr = ADDR_W'(a);
            #1;
            checks++;
            if (cpu_rd_data !== m_mem[a]) begin
                errors++;
                $display("FAIL %s addr %0d: got %h expected %h", tag, a, cpu_rd_data, m_mem[a]);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (run !== 1'b0 || load_ack !== 1'b0 || wr_count !== 5'd0 || prot_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: run=%b ack=%b cnt=%0d prot=%b expected 0 0 0 0",
                     run, load_ack, wr_count, prot_err);
        end
        addr_mode = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            sw_addr = ADDR_W'(a);
            #1;
            checks++;
            if (cpu_rd_data !== 8'h00 || load_addr !== ADDR_W'(a)) begin
                errors++;
                $display("FAIL reset_read addr %0d: data %h load_addr %0d expected 00 %0d",
                         a, cpu_rd_data, load_addr, a);
            end
        end
    endtask

    task automatic test_direct_load();
        int acks, first;
        addr_mode = 1'b0; sw_addr = 4'h3; sw_data = 8'hA5;
        press(1'b0, 1'b1, acks, first);
        checks++;
        if (acks !== 1 || first !== 2 + DEB + 1) begin
            errors++;
            $display("FAIL direct_ack: acks %0d at cycle %0d expected 1 at %0d", acks, first, 2 + DEB + 1);
        end
        sw_addr = 4'h3; #1;
        checks++;
        if (cpu_rd_data !== 8'hA5 || wr_count !== 5'd1) begin
            errors++;
            $display("FAIL direct_data: data %h cnt %0d expected a5 1", cpu_rd_data, wr_count);
        end
        for (int k = 0; k < 6; k++) begin
            sw_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            sw_data = DATA_W'($urandom);
            press(1'b0, 1'b1, acks, first);
            checks++;
            if (acks !== 1) begin
                errors++;
                $display("FAIL random_load_ack %0d: acks %0d expected 1", k, acks);
            end
        end
        checks++;
        if (wr_count !== 5'(m_cnt)) begin
            errors++;
            $display("FAIL direct_count: got %0d expected %0d", wr_count, m_cnt);
        end
        readback_all("direct_readback");
    endtask

    task automatic test_bouncy();
        int acks, first;
        addr_mode = 1'b0;
        sw_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        sw_data = DATA_W'($urandom);
        press(1'b1, 1'b1, acks, first);
        checks++;
        if (acks !== 1 || wr_count !== 5'(m_cnt)) begin
            errors++;
            $display("FAIL bouncy: acks %0d cnt %0d expected 1 %0d", acks, wr_count, m_cnt);
        end
        readback_all("bouncy_readback");
    endtask

    task automatic test_auto_inc();
        int acks, first, bad;
        apply_reset();
        addr_mode = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            sw_data = DATA_W'(8'h11 * (k + 1));
            press(1'b0, 1'b1, acks, first);
            if (acks != 1) bad++;
        end
        checks++;
        if (bad !== 0 || load_addr !== ADDR_W'(m_ptr) || m_ptr != 4) begin
            errors++;
            $display("FAIL auto_four: bad acks %0d load_addr %0d expected 0 4", bad, load_addr);
        end
        readback_all("auto_readback");
        addr_mode = 1'b1; #1;
        checks++;
        if (load_addr !== 4'd4) begin
            errors++;
            $display("FAIL auto_mode_switch: load_addr %0d expected 4", load_addr);
        end
        for (int k = 0; k < 16; k++) begin
            sw_data = DATA_W'($urandom);
            press(1'b0, 1'b1, acks, first);
            if (acks != 1) bad++;
        end
        checks++;
        if (bad !== 0 || load_addr !== 4'd4 || wr_count !== 5'd20 || m_cnt != 20) begin
            errors++;
            $display("FAIL auto_wrap: bad %0d load_addr %0d cnt %0d expected 0 4 20", bad, load_addr, wr_count);
        end
        readback_all("wrap_readback");
    endtask

    task automatic test_saturation();
        int acks, first;
        addr_mode = 1'b1;
        for (int k = 0; k < 12; k++) begin
            sw_data = DATA_W'($urandom);
            press(1'b0, 1'b1, acks, first);
        end
        checks++;
        if (wr_count !== 5'd31 || m_cnt != 31) begin
            errors++;
            $display("FAIL saturation: got %0d expected 31", wr_count);
        end
        readback_all("sat_readback");
    endtask

    task automatic test_start_with_press();
        int acks, first;
        logic [DATA_W-1:0] d, old;
        addr_mode = 1'b0; sw_addr = 4'h5; sw_data = DATA_W'($urandom);
        cpu_addr = 4'd12; cpu_wr_data = 8'hEE;
        acks = 0;
        for (int i = 0; i < WIN; i++) begin
            load_btn = (i < 10);
            if (i == 6) begin start = 1'b1; cpu_wr_en = 1'b1; end
            if (i == 8) cpu_wr_en = 1'b0;
            tick();
            if (load_ack === 1'b1) acks++;
            if (i == 6) begin
                checks++;
                if (load_ack !== 1'b1 || run !== 1'b0) begin
                    errors++;
                    $display("FAIL sp_write_cycle: ack %b run %b expected 1 0", load_ack, run);
                end
            end
            if (i == 7) begin
                checks++;
                if (load_ack !== 1'b0 || run !== 1'b1) begin
                    errors++;
                    $display("FAIL sp_run_entry: ack %b run %b expected 0 1", load_ack, run);
                end
            end
        end
        load_btn = 1'b0;
        model_load();
        checks++;
        if (acks !== 1 || cpu_rd_data !== m_mem[12]) begin
            errors++;
            $display("FAIL sp_ignored_write: acks %0d mem12 %h expected 1 %h", acks, cpu_rd_data, m_mem[12]);
        end
        cpu_addr = 4'd5; #1;
        checks++;
        if (cpu_rd_data !== m_mem[5]) begin
            errors++;
            $display("FAIL sp_loaded: mem5 %h expected %h", cpu_rd_data, m_mem[5]);
        end
        // presses are discarded while running
        press(1'b0, 1'b0, acks, first);
        checks++;
        if (acks !== 0 || run !== 1'b1) begin
            errors++;
            $display("FAIL run_press_discard: acks %0d run %b expected 0 1", acks, run);
        end
        // core writes in RUN, first the fixed one, then random ones
        for (int k = 0; k < 21; k++) begin
            cpu_addr    = (k == 0) ? 4'd9 : ADDR_W'($urandom_range(0, DEPTH - 1));
            cpu_wr_data = (k == 0) ? 8'h5A : DATA_W'($urandom);
            cpu_wr_en   = 1'b1;
            old         = m_mem[cpu_addr];
            #1;
            checks++;
            if (cpu_rd_data !== old) begin
                errors++;
                $display("FAIL rdw_old %0d: got %h expected %h", k, cpu_rd_data, old);
            end
            tick();
            cpu_wr_en = 1'b0;
            model_cpu_write(int'(cpu_addr), cpu_wr_data);
            d = m_mem[cpu_addr];
            #1;
            checks++;
            if (cpu_rd_data !== d) begin
                errors++;
                $display("FAIL run_write %0d addr %0d: got %h expected %h", k, cpu_addr, cpu_rd_data, d);
            end
        end
        checks++;
        if (prot_err !== m_prot) begin
            errors++;
            $display("FAIL run_prot_flag: got %b expected %b", prot_err, m_prot);
        end
        start = 1'b0; #1;
        checks++;
        if (run !== 1'b1) begin
            errors++;
            $display("FAIL run_hold: run %b expected 1", run);
        end
        tick();
        checks++;
        if (run !== 1'b0) begin
            errors++;
            $display("FAIL run_exit: run %b expected 0", run);
        end
        readback_all("run_readback");
    endtask

    task automatic test_protect();
        int acks, first;
        apply_reset();
        start = 1'b1; tick();
        for (int k = 0; k < 2; k++) begin
            cpu_addr    = (k == 0) ? 4'd2 : 4'd8;
            cpu_wr_data = (k == 0) ? 8'hC3 : 8'h3C;
            cpu_wr_en   = 1'b1;
            tick();
            cpu_wr_en = 1'b0;
            model_cpu_write(int'(cpu_addr), cpu_wr_data);
            #1;
            checks++;
            if (cpu_rd_data !== m_mem[cpu_addr] || prot_err !== m_prot || run !== 1'b1) begin
                errors++;
                $display("FAIL protect_write addr %0d: data %h prot %b run %b expected %h %b 1",
                         cpu_addr, cpu_rd_data, prot_err, run, m_mem[cpu_addr], m_prot);
            end
        end
        start = 1'b0; tick(); tick();
        // loader writes to a protected address are always allowed
        addr_mode = 1'b0; sw_addr = 4'd2; sw_data = 8'h96;
        press(1'b0, 1'b1, acks, first);
        checks++;
        if (prot_err !== m_prot || acks !== 1) begin
            errors++;
            $display("FAIL protect_sticky: prot %b acks %0d expected %b 1", prot_err, acks, m_prot);
        end
        readback_all("protect_readback");
        apply_reset();
        checks++;
        if (prot_err !== 1'b0) begin
            errors++;
            $display("FAIL protect_reset: prot %b expected 0", prot_err);
        end
    endtask

    task automatic test_reset_during_write();
        bit seen;
        addr_mode = 1'b0; sw_addr = 4'd6; sw_data = 8'h77;
        seen = 1'b0;
        for (int i = 0; i < WIN && !seen; i++) begin
            load_btn = (i < 10);
            tick();
            if (load_ack === 1'b1) begin
                seen = 1'b1;
                reset = 1'b1; load_btn = 1'b0;
                tick();
                reset = 1'b0;
            end
        end
        load_btn = 1'b0;
        model_reset();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_write_timeout: no load_ack within %0d cycles", WIN);
        end
        sw_addr = 4'd6; #1;
        checks++;
        if (cpu_rd_data !== 8'h00 || wr_count !== 5'd0 || run !== 1'b0) begin
            errors++;
            $display("FAIL rst_write_abort: data %h cnt %0d run %b expected 00 0 0", cpu_rd_data, wr_count, run);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_direct_load();
        test_bouncy();
        test_auto_inc();
        test_saturation();
        test_start_with_press();
        test_protect();
        test_reset_during_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
